// File: rtl/lighter_seq.sv
// Commanded light-chaser sequencer: runs chase-left/right, bounce or fill on l for N passes.
// Latency: accept -> start pattern on l next cycle; completing step -> l=0 + done next cycle.
// Backpressure: cmd_ready high only while idle; commands offered during a run are dropped.
//
// Ports:
//   clk, reset      - rising-edge clock, synchronous active-low reset
//   enable          - run gate; low freezes divider, pattern and pass count
//   stop            - aborts a running sequence (l cleared, no done)
//   cmd_valid/ready - command handshake; cmd_mode/div/cycles captured on accept
//   l               - registered lamp pattern (LSB = lamp 0)
//   busy            - high while a sequence runs
//   done            - one-cycle pulse after the final pass completes
module lighter_seq #(
  parameter int WIDTH = 5,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             stop,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [DIV_W-1:0] cmd_div,
  input  logic [3:0]       cmd_cycles,
  output logic [WIDTH-1:0] l,
  output logic             busy,
  output logic             done
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [1:0] M_LEFT   = 2'd0;
  localparam logic [1:0] M_RIGHT  = 2'd1;
  localparam logic [1:0] M_BOUNCE = 2'd2;
  localparam logic [1:0] M_FILL   = 2'd3;

  localparam logic [WIDTH-1:0] LSB_ONLY = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  logic [0:0]       state_q,  state_d;
  logic [1:0]       mode_q,   mode_d;
  logic [DIV_W-1:0] div_q,    div_d;
  logic [3:0]       cycles_q, cycles_d;
  logic [DIV_W-1:0] cnt_q,    cnt_d;
  logic [3:0]       pass_q,   pass_d;
  logic             dir_q,    dir_d;   // bounce direction: 0 toward MSB, 1 toward LSB
  logic [WIDTH-1:0] l_q,      l_d;
  logic             done_q,   done_d;

  logic [WIDTH-1:0] step_pat;
  logic             step_dir;
  logic             pass_end;
  logic [3:0]       pass_inc;
  logic             finish;

  // Pattern after one step. Every pass-completing step lands on the mode's
  // start pattern, so wrapping needs no separate reload path.
  always_comb begin
    step_pat = l_q;
    step_dir = dir_q;
    pass_end = 1'b0;
    case (mode_q)
      M_LEFT: begin
        step_pat = {l_q[WIDTH-2:0], l_q[WIDTH-1]};
        pass_end = l_q[WIDTH-1];
      end
      M_RIGHT: begin
        step_pat = {l_q[0], l_q[WIDTH-1:1]};
        pass_end = l_q[0];
      end
      M_BOUNCE: begin
        if (!dir_q) begin
          step_pat = l_q << 1;
          step_dir = step_pat[WIDTH-1];
        end else begin
          step_pat = l_q >> 1;
          step_dir = ~step_pat[0];
          pass_end = step_pat[0];
        end
      end
      default: begin // fill: ones shift in, then one dark step, then restart
        if (l_q == ALL_ONES) begin
          step_pat = '0;
        end else if (l_q == '0) begin
          step_pat = LSB_ONLY;
          pass_end = 1'b1;
        end else begin
          step_pat = {l_q[WIDTH-2:0], 1'b1};
        end
      end
    endcase
  end

  // Endless runs (cycles==0) saturate the pass count instead of wrapping.
  assign pass_inc = (pass_q == 4'hF) ? pass_q : pass_q + 4'd1;
  assign finish   = pass_end && (cycles_q != 4'd0) && (pass_inc == cycles_q);

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    div_d    = div_q;
    cycles_d = cycles_q;
    cnt_d    = cnt_q;
    pass_d   = pass_q;
    dir_d    = dir_q;
    l_d      = l_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d  = S_RUN;
          mode_d   = cmd_mode;
          div_d    = cmd_div;
          cycles_d = cmd_cycles;
          cnt_d    = '0;
          pass_d   = '0;
          dir_d    = 1'b0;
          l_d      = (cmd_mode == M_RIGHT) ? MSB_ONLY : LSB_ONLY;
        end
      end
      default: begin
        // Stop is checked first so it beats a coincident step or completion.
        if (stop) begin
          state_d = S_IDLE;
          l_d     = '0;
        end else if (enable) begin
          if (cnt_q == div_q) begin
            cnt_d = '0;
            if (pass_end) begin
              pass_d = pass_inc;
            end
            if (finish) begin
              state_d = S_IDLE;
              l_d     = '0;
              done_d  = 1'b1;
            end else begin
              l_d   = step_pat;
              dir_d = step_dir;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      mode_q   <= M_LEFT;
      div_q    <= '0;
      cycles_q <= '0;
      cnt_q    <= '0;
      pass_q   <= '0;
      dir_q    <= 1'b0;
      l_q      <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      div_q    <= div_d;
      cycles_q <= cycles_d;
      cnt_q    <= cnt_d;
      pass_q   <= pass_d;
      dir_q    <= dir_d;
      l_q      <= l_d;
      done_q   <= done_d;
    end
  end

  assign l         = l_q;
  assign done      = done_q;
  assign busy      = (state_q == S_RUN);
  assign cmd_ready = (state_q == S_IDLE);

endmodule

// File: tb/tb_lighter_seq.sv
// Self-checking bench for lighter_seq: expected per-cycle outputs are queued
// when a command is issued and popped/compared on each falling edge.
module tb_lighter_seq;

  localparam int WIDTH = 5;
  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             stop;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_mode;
  logic [DIV_W-1:0] cmd_div;
  logic [3:0]       cmd_cycles;
  logic [WIDTH-1:0] l;
  logic             busy;
  logic             done;

  lighter_seq #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .stop       (stop),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_mode   (cmd_mode),
    .cmd_div    (cmd_div),
    .cmd_cycles (cmd_cycles),
    .l          (l),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] l;
    logic             busy;
    logic             done;
    logic             rdy;
  } exp_t;

  exp_t  sb_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  string cur   = "reset";

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s/%s: got %0h expected %0h", cur, tag, got, exp);
    end
  endtask

  // Pass patterns written out directly from the lamp sequences.
  function automatic int pass_len(input int mode);
    case (mode)
      2:       return 2 * (WIDTH - 1);
      3:       return WIDTH + 1;
      default: return WIDTH;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] pat(input int mode, input int i);
    int v;
    case (mode)
      0:       v = 1 << i;
      1:       v = 1 << (WIDTH - 1 - i);
      2:       v = (i < WIDTH) ? (1 << i) : (1 << (2 * (WIDTH - 1) - i));
      default: v = (i < WIDTH) ? ((1 << (i + 1)) - 1) : 0;
    endcase
    return WIDTH'(v);
  endfunction

  task automatic push(input logic [WIDTH-1:0] lv, input logic b, input logic d, input logic r);
    exp_t e;
    e.l = lv; e.busy = b; e.done = d; e.rdy = r;
    sb_q.push_back(e);
  endtask

  // Full finite sequence: patterns held div+1 cycles, then done, then idle.
  task automatic push_cmd(input int mode, input int div, input int cycles);
    for (int p = 0; p < cycles; p++)
      for (int s = 0; s < pass_len(mode); s++)
        for (int h = 0; h <= div; h++)
          push(pat(mode, s), 1'b1, 1'b0, 1'b0);
    push('0, 1'b0, 1'b1, 1'b1);
    push('0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic cyc();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("l",    32'(l),         32'(e.l));
      chk("busy", 32'(busy),      32'(e.busy));
      chk("done", 32'(done),      32'(e.done));
      chk("rdy",  32'(cmd_ready), 32'(e.rdy));
    end
  endtask

  task automatic issue(input logic [1:0] mode, input int div, input logic [3:0] cycles);
    cmd_valid  = 1'b1;
    cmd_mode   = mode;
    cmd_div    = DIV_W'(div);
    cmd_cycles = cycles;
    cyc();
    cmd_valid  = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 2000 && sb_q.size() > 0; n++) cyc();
    chk("drained", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; stop = 1'b0; cmd_valid = 1'b0;
    cmd_mode = 2'd0; cmd_div = '0; cmd_cycles = '0;
    @(negedge clk);

    // Reset held 5 cycles, then released.
    repeat (5) cyc();
    chk("rst_l", 32'(l), 32'd0);
    reset = 1'b1;
    cyc();
    chk("l",    32'(l),         32'd0);
    chk("busy", 32'(busy),      32'd0);
    chk("done", 32'(done),      32'd0);
    chk("rdy",  32'(cmd_ready), 32'd1);

    cur = "chase_left";
    push_cmd(0, 0, 1);
    issue(2'd0, 0, 4'd1);
    drain();

    cur = "bounce";
    push_cmd(2, 1, 1);
    issue(2'd2, 1, 4'd1);
    drain();

    // Fill x2; a stray command mid-run must not disturb it.
    cur = "fill";
    push_cmd(3, 0, 2);
    issue(2'd3, 0, 4'd2);
    for (int n = 0; n < 200 && sb_q.size() > 0; n++) begin
      cmd_valid = (n == 4);
      cmd_mode  = 2'd0;
      cmd_div   = DIV_W'(7);
      cyc();
    end
    cmd_valid = 1'b0;
    chk("drained", 32'(sb_q.size()), 32'd0);

    // Chase-right endless, div=3; enable low for 5 cycles during the second
    // pattern stretches it to 9 cycles. 80 cycles covers more than 3 passes.
    cur = "chase_right";
    begin
      int pushed = 0;
      for (int p = 0; p < 6 && pushed < 80; p++)
        for (int s = 0; s < WIDTH && pushed < 80; s++)
          for (int h = 0; h < ((p == 0 && s == 1) ? 9 : 4) && pushed < 80; h++) begin
            push(pat(1, s), 1'b1, 1'b0, 1'b0);
            pushed++;
          end
    end
    push('0, 1'b0, 1'b0, 1'b1);   // stop: dark, idle, no done
    push('0, 1'b0, 1'b0, 1'b1);
    issue(2'd1, 3, 4'd0);
    for (int i = 1; i < 80; i++) begin
      enable = !(i >= 6 && i <= 10);
      cyc();
    end
    stop = 1'b1; enable = 1'b0;     // stop must act even when frozen
    cyc();
    stop = 1'b0; enable = 1'b1;
    cyc();
    chk("drained", 32'(sb_q.size()), 32'd0);

    // Bounce interrupted by reset at 01000, then immediate new command.
    cur = "reset_mid";
    for (int s = 0; s < 4; s++) push(pat(2, s), 1'b1, 1'b0, 1'b0);
    issue(2'd2, 0, 4'd1);
    repeat (3) cyc();
    reset = 1'b0;
    push('0, 1'b0, 1'b0, 1'b1);
    cyc();
    reset = 1'b1;
    chk("drained", 32'(sb_q.size()), 32'd0);

    cur = "after_reset";
    push_cmd(0, 0, 1);
    issue(2'd0, 0, 4'd1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
